lsu_bus_ctrl: RTL and testbench
===============================

Name: lsu_bus_ctrl

Overview:
- Load/store stage downstream of the decoder/ALU in the single-cycle core.
- Takes the decoded memory command with the ALU-computed effective address and runs one transaction on a valid/ack data-memory bus.
- Handles byte-lane steering, strobes and sign/zero extension, and stalls the core until the access retires.
- Flags misaligned/illegal accesses and bus timeouts instead of issuing or hanging.

Parameters:
- TIMEOUT_CYCLES, 255: maximum REQ cycles without memAck before a bus error; legal range 1..65535.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- lsEn  in  1  current instruction is a load or store.
- isStore  in  1  1 = store, 0 = load.
- lsMode  in  3  [1:0] size: 0 byte, 1 half, 2 word, 3 illegal; [2] 1 = zero-extend load.
- addr  in  32  effective byte address (ALU result).
- storeData  in  32  rs2 value; low bytes used for sub-word stores.
- stall  out  1  hold PC/register writes this cycle.
- loadData  out  32  extended load result; valid while loadValid = 1.
- loadValid  out  1  one-cycle pulse, load retired successfully.
- misalign  out  1  one-cycle pulse, access misaligned or size illegal.
- busError  out  1  one-cycle pulse, timeout elapsed.
- memReq  out  1  bus request, held until ack or timeout.
- memWe  out  1  write enable, stable while memReq = 1.
- memAddr  out  32  word address: {addr[31:2], 2'b00}.
- memWstrb  out  4  byte strobes, bit i = byte lane i.
- memWdata  out  32  lane-replicated store data.
- memRdata  in  32  read data, valid in memAck cycle.
- memAck  in  1  completes the transaction in the cycle it is high with memReq.

Behaviour:
- Reset, asynchronous on reset = 0:
  - state = IDLE, timeout counter = 0.
  - All registered outputs = 0, including loadData, memAddr, memWstrb and memWdata.
  - If reset asserts mid-transaction, memReq drops immediately and the access is abandoned with no pulse.
- States: IDLE, REQ, DONE.
- IDLE:
  - stall = lsEn, combinational.
  - When lsEn = 1, register the address, mode, data and strobes at the clock edge.
  - Aligned and legal access: go to REQ; memReq = 1 from the next cycle.
  - Misaligned (half with addr[0] = 1, word with addr[1:0] != 0) or size 3: go to DONE with the fault flag set; no bus activity.
- REQ:
  - stall = 1; memReq, memWe, memAddr, memWstrb and memWdata are held constant.
  - On memAck = 1:
    - Load: register the extended memRdata into loadData.
    - Go to DONE with success.
  - Counter increments each REQ cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES, drop memReq, set loadData = 0 and go to DONE with the error flag set.
  - The ack check has priority over the timeout check within the same cycle.
- DONE:
  - stall = 0, so the instruction retires this cycle; lsEn is ignored in this cycle (it belongs to the retiring instruction).
  - Exactly one pulse is asserted:
    - loadValid, for a successful load;
    - misalign, for a fault;
    - busError, for a timeout;
    - none, for a successful store.
  - Next state is IDLE; counter cleared.
- Latency:
  - Acked in the first REQ cycle: lsEn cycle N, memReq in N+1, DONE in N+2 (stall high for 2 cycles).
  - Misaligned/illegal: stall high for 1 cycle, misalign pulse in N+1.
- Store lanes (little-endian):
  - byte: memWdata = {4{storeData[7:0]}}, memWstrb = 1 << addr[1:0].
  - half: memWdata = {2{storeData[15:0]}}, memWstrb = 0011 (addr[1] = 0) or 1100.
  - word: memWdata = storeData, memWstrb = 1111.
- Loads: memWstrb = 0000, memWe = 0.
  - Byte lane addr[1:0] / half lane addr[1] is selected, then sign-extended (lsMode[2] = 0) or zero-extended (lsMode[2] = 1).
  - Word loads ignore lsMode[2].
- memAck while memReq = 0 is ignored.

Test Plan:
- Word load from 0x100 with memRdata = 0xDEADBEEF, ack in the first REQ cycle -> stall high 2 cycles; memAddr = 0x100, memWe = 0; loadValid pulse with loadData = 0xDEADBEEF.
- Byte load from 0x103, memRdata = 0x80112233:
  - signed -> loadData = 0xFFFFFF80;
  - unsigned -> 0x00000080.
- Half store of 0x0000ABCD to 0x202 -> memAddr = 0x200, memWstrb = 1100, memWdata = 0xABCDABCD, memWe = 1; no pulses; stall released in DONE.
- Word load at 0x101 and size-3 access -> no memReq; stall for exactly 1 cycle; misalign pulse.
- TIMEOUT_CYCLES = 4, memAck never asserted -> memReq high exactly 4 cycles, then busError pulse, loadData = 0. Repeat with ack in the 4th cycle -> success, no busError.
- reset driven low during REQ -> memReq and stall fall without waiting for a clock edge. After release, state is IDLE and a new word store completes normally.

Source files
------------

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl -- load/store stage between the ALU and the data-memory bus.
// It takes one decoded memory command and runs it as a single valid/ack bus
// transaction. It steers byte lanes and strobes, sign- or zero-extends load
// data, and stalls the core until the access retires. Misaligned or
// illegal-size accesses are flagged without touching the bus. A request that
// is never acked is abandoned after TIMEOUT_CYCLES and reported as a bus error.
//
// Ports
//   clk, reset          core clock (rising edge), async active-low reset
//   lsEn, isStore       load/store command, direction
//   lsMode[2:0]         [1:0] size (0 B, 1 H, 2 W, 3 illegal), [2] zero-extend
//   addr, storeData     effective byte address, rs2 value
//   stall               hold PC/regfile (combinational)
//   loadData/loadValid  extended load result + one-cycle retire pulse
//   misalign, busError  one-cycle fault pulses
//   memReq/We/Addr/Wstrb/Wdata, memRdata, memAck   data-memory bus
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsEn,
  input  logic        isStore,
  input  logic [2:0]  lsMode,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        stall,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        misalign,
  output logic        busError,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memWstrb,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memAck
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  mode_q;
  logic [1:0]  lane_q;

  logic        bad;
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n;

  // Alignment / size legality of the incoming command.
  always_comb begin
    case (lsMode[1:0])
      2'd0:    bad = 1'b0;
      2'd1:    bad = addr[0];
      2'd2:    bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
  end

  // Store lane replication and strobes; loads never assert strobes.
  always_comb begin
    case (lsMode[1:0])
      2'd0: begin
        wdata_n = {4{storeData[7:0]}};
        wstrb_n = 4'b0001 << addr[1:0];
      end
      2'd1: begin
        wdata_n = {2{storeData[15:0]}};
        wstrb_n = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_n = storeData;
        wstrb_n = 4'b1111;
      end
    endcase
    if (!isStore) wstrb_n = 4'b0000;
  end

  // Select the addressed lane of the read word and extend it to 32 bits.
  function automatic logic [31:0] extend(input logic [2:0]  mode,
                                         input logic [1:0]  lane,
                                         input logic [31:0] rdata);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = rdata >> {lane, 3'b000};
    b  = sh[7:0];
    h  = lane[1] ? rdata[31:16] : rdata[15:0];
    case (mode[1:0])
      2'd0:    extend = mode[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    extend = mode[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: extend = rdata;
    endcase
  endfunction

  // Gated by reset so an abandoned access releases the core at once.
  assign stall = reset & (((state == IDLE) & lsEn) | (state == REQ));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= '0;
      lane_q    <= '0;
      loadData  <= '0;
      loadValid <= 1'b0;
      misalign  <= 1'b0;
      busError  <= 1'b0;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWstrb  <= '0;
      memWdata  <= '0;
    end else begin
      // Pulses live only for the single DONE cycle.
      loadValid <= 1'b0;
      misalign  <= 1'b0;
      busError  <= 1'b0;
      case (state)
        IDLE: begin
          if (lsEn) begin
            memAddr  <= {addr[31:2], 2'b00};
            memWe    <= isStore;
            memWstrb <= wstrb_n;
            memWdata <= wdata_n;
            mode_q   <= lsMode;
            lane_q   <= addr[1:0];
            if (bad) begin
              misalign <= 1'b1;
              state    <= DONE;
            end else begin
              memReq <= 1'b1;
              state  <= REQ;
            end
          end
        end
        REQ: begin
          // Ack wins over a timeout landing in the same cycle.
          if (memAck) begin
            memReq <= 1'b0;
            cnt    <= '0;
            state  <= DONE;
            if (!memWe) begin
              loadData  <= extend(mode_q, lane_q, memRdata);
              loadValid <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            memReq   <= 1'b0;
            loadData <= '0;
            busError <= 1'b1;
            cnt      <= '0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          // Retire cycle: lsEn still belongs to the retiring instruction.
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
module tb_lsu_bus_ctrl;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsEn, isStore, memAck;
  logic [2:0]  lsMode;
  logic [31:0] addr, storeData, memRdata;
  logic        stall, loadValid, misalign, busError, memReq, memWe;
  logic [31:0] loadData, memAddr, memWdata;
  logic [3:0]  memWstrb;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .lsEn(lsEn), .isStore(isStore), .lsMode(lsMode),
    .addr(addr), .storeData(storeData), .stall(stall), .loadData(loadData),
    .loadValid(loadValid), .misalign(misalign), .busError(busError),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWstrb(memWstrb),
    .memWdata(memWdata), .memRdata(memRdata), .memAck(memAck)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lv, mis, be;
    logic [31:0] data;
    int          reqc, stallc;
    logic [31:0] baddr, bdata;
    logic [3:0]  bstrb;
    logic        bwe;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic lv, mis, be, input logic [31:0] data,
                              input int reqc, stallc, input logic [31:0] baddr,
                              input logic [3:0] bstrb, input logic bwe,
                              input logic [31:0] bdata);
    exp_t e;
    e.lv = lv; e.mis = mis; e.be = be; e.data = data;
    e.reqc = reqc; e.stallc = stallc; e.baddr = baddr;
    e.bstrb = bstrb; e.bwe = bwe; e.bdata = bdata;
    return e;
  endfunction

  // Called at a negedge with the DUT in IDLE. ack_at = REQ cycle (1-based)
  // in which memAck is driven, 0 = never.
  task automatic access(input string tag, input logic st, input logic [2:0] mode,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rd, input int ack_at, input exp_t e);
    exp_t x;
    int   reqc, stallc;
    bit   done;
    sb.push_back(e);
    lsEn = 1'b1; isStore = st; lsMode = mode; addr = a; storeData = sd; memAck = 1'b0;
    #1;
    chk({tag, "_stall_issue"}, stall, 1);
    stallc = 1; reqc = 0; done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      memAck = 1'b0;
      memRdata = 32'h5A5A_5A5A;
      if (memReq) begin
        reqc++;
        if (stall) stallc++;
        if (reqc == 1) begin
          chk({tag, "_memAddr"}, memAddr, x_addr(e));
          chk({tag, "_memWe"}, memWe, e.bwe);
          chk({tag, "_memWstrb"}, memWstrb, e.bstrb);
          if (e.bwe) chk({tag, "_memWdata"}, memWdata, e.bdata);
        end
        if (reqc == ack_at) begin
          memAck = 1'b1;
          memRdata = rd;
        end
      end else if (!stall) begin
        done = 1;
        x = sb.pop_front();
        chk({tag, "_loadValid"}, loadValid, x.lv);
        chk({tag, "_misalign"}, misalign, x.mis);
        chk({tag, "_busError"}, busError, x.be);
        if (x.lv || x.be) chk({tag, "_loadData"}, loadData, x.data);
        chk({tag, "_req_cycles"}, reqc, x.reqc);
        chk({tag, "_stall_cycles"}, stallc, x.stallc);
        lsEn = 1'b0;
        break;
      end else begin
        stallc++;
      end
    end
    chk({tag, "_retired"}, done, 1);
    if (!done) begin
      void'(sb.pop_front());
      lsEn = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_idle_no_pulse"}, {loadValid, misalign, busError, stall}, 0);
  endtask

  function automatic logic [31:0] x_addr(input exp_t e);
    return e.baddr;
  endfunction

  initial begin
    reset = 1'b0; lsEn = 1'b0; isStore = 1'b0; lsMode = 3'd0; addr = '0;
    storeData = '0; memRdata = '0; memAck = 1'b0;
    #12;
    chk("rst_outputs", {memReq, stall, loadValid, misalign, busError, memWe, memWstrb}, 0);
    chk("rst_loadData", loadData, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memWdata", memWdata, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    access("lw100", 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 1,
           mk(1, 0, 0, 32'hDEADBEEF, 1, 2, 32'h100, 4'b0000, 0, 0));
    access("lb103s", 0, 3'b000, 32'h103, 0, 32'h80112233, 1,
           mk(1, 0, 0, 32'hFFFFFF80, 1, 2, 32'h100, 4'b0000, 0, 0));
    access("lbu103", 0, 3'b100, 32'h103, 0, 32'h80112233, 1,
           mk(1, 0, 0, 32'h00000080, 1, 2, 32'h100, 4'b0000, 0, 0));
    access("lh102s", 0, 3'b001, 32'h102, 0, 32'h80112233, 1,
           mk(1, 0, 0, 32'hFFFF8011, 1, 2, 32'h100, 4'b0000, 0, 0));
    access("sh202", 1, 3'b001, 32'h202, 32'h0000ABCD, 0, 1,
           mk(0, 0, 0, 0, 1, 2, 32'h200, 4'b1100, 1, 32'hABCDABCD));
    access("sb301", 1, 3'b000, 32'h301, 32'hAABBCC55, 0, 2,
           mk(0, 0, 0, 0, 2, 3, 32'h300, 4'b0010, 1, 32'h55555555));
    access("lw101", 0, 3'b010, 32'h101, 0, 0, 1,
           mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    access("size3", 0, 3'b011, 32'h000, 0, 0, 1,
           mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    access("tmo", 0, 3'b010, 32'h400, 0, 0, 0,
           mk(0, 0, 1, 32'h0, 4, 5, 32'h400, 4'b0000, 0, 0));
    access("ack4", 0, 3'b010, 32'h400, 0, 32'h12345678, 4,
           mk(1, 0, 0, 32'h12345678, 4, 5, 32'h400, 4'b0000, 0, 0));

    // Stray ack with no request outstanding.
    memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    chk("stray_ack", {memReq, loadValid, misalign, busError, stall}, 0);

    // Reset in the middle of a request.
    lsEn = 1'b1; isStore = 1'b0; lsMode = 3'b010; addr = 32'h500;
    @(negedge clk);
    chk("rstmid_req", memReq, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_memReq", memReq, 0);
    chk("rstmid_stall", stall, 0);
    chk("rstmid_pulses", {loadValid, misalign, busError}, 0);
    lsEn = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {memReq, stall, loadValid, misalign, busError}, 0);
    access("sw600", 1, 3'b010, 32'h600, 32'hCAFEF00D, 0, 1,
           mk(0, 0, 0, 0, 1, 2, 32'h600, 4'b1111, 1, 32'hCAFEF00D));

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end
endmodule
